// File: rtl/systolic_feed_ctrl.sv
// Sequences one pass of an N x N output-stationary array: SRAM reads, diagonal skew, PE control.
// Latency: CLEAR 1 cycle, FEED K cycles, DRAIN 2N-1 cycles; result_valid 2N+K+1 cycles after start.
// Backpressure: results are held valid in HOLD until result_ack; start is only taken in IDLE.
module systolic_feed_ctrl #(
  parameter int N      = 4,
  parameter int K      = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3   // 2**ADDR_W must cover K words
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [N*DATA_W-1:0] act_rd_data,
  input  logic [N*DATA_W-1:0] wgt_rd_data,
  output logic [N*DATA_W-1:0] act_out,
  output logic [N*DATA_W-1:0] wgt_out,
  output logic                pe_en,
  output logic                pe_clr,
  output logic                result_valid,
  input  logic                result_ack
);

  localparam int MAXD = (K > 2*N) ? K : 2*N;
  localparam int CW   = $clog2(MAXD) + 1;
  localparam logic [CW-1:0] FEED_LAST  = CW'(K - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2*N - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              pe_en_q;
  logic              pe_clr_q;
  logic              result_valid_q;

  // Look-ahead for the read issued in the next FEED cycle: word cnt+2 while it still exists.
  logic [CW-1:0]     cnt_d;
  logic              feed_rd_d;
  logic [ADDR_W-1:0] feed_addr_d;

  // Counter increment and next-read address/strobe, derived from the current FEED count.
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    feed_rd_d   = (32'(cnt_q) + 32'd2) < 32'(K);
    feed_addr_d = '0;
    if (feed_rd_d) begin
      feed_addr_d = ADDR_W'(cnt_q + CW'(2));
    end
  end

  // Pass sequencer: state, counter and all control outputs are registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      pe_en_q        <= 1'b0;
      pe_clr_q       <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            pe_clr_q  <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        S_CLEAR: begin
          state_q  <= S_FEED;
          cnt_q    <= '0;
          pe_clr_q <= 1'b0;
          pe_en_q  <= 1'b1;
          // Word 0 was read in CLEAR; the first FEED cycle reads word 1 if the pass has one.
          if (K > 1) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= ADDR_W'(1);
          end else begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
          end
        end
        S_FEED: begin
          if (cnt_q == FEED_LAST) begin
            state_q   <= S_DRAIN;
            cnt_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            cnt_q     <= cnt_d;
            rd_en_q   <= feed_rd_d;
            rd_addr_q <= feed_addr_d;
          end
        end
        S_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q        <= S_HOLD;
            cnt_q          <= '0;
            pe_en_q        <= 1'b0;
            result_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_HOLD: begin
          // A start coincident with the ack is dropped: IDLE must see it afresh.
          if (result_ack) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q        <= S_IDLE;
          cnt_q          <= '0;
          busy_q         <= 1'b0;
          rd_en_q        <= 1'b0;
          rd_addr_q      <= '0;
          pe_en_q        <= 1'b0;
          pe_clr_q       <= 1'b0;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign pe_en        = pe_en_q;
  assign pe_clr       = pe_clr_q;
  assign result_valid = result_valid_q;

  // SRAM data only counts in FEED; everywhere else zeros are pushed into the skew lanes.
  logic [N*DATA_W-1:0] act_gated;
  logic [N*DATA_W-1:0] wgt_gated;

  // Gate the returned SRAM words by FEED so stale read data never enters the array.
  always_comb begin
    act_gated = '0;
    wgt_gated = '0;
    if (state_q == S_FEED) begin
      act_gated = act_rd_data;
      wgt_gated = wgt_rd_data;
    end
  end

  // Diagonal skew: lane i passes through i zero-reset register stages.
  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign act_out[DATA_W-1:0] = act_gated[DATA_W-1:0];
      assign wgt_out[DATA_W-1:0] = wgt_gated[DATA_W-1:0];
    end else begin : g_delay
      logic [DATA_W-1:0] act_q [i];
      logic [DATA_W-1:0] wgt_q [i];

      // Shift the lane along its delay line one stage per cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < i; s++) begin
            act_q[s] <= '0;
            wgt_q[s] <= '0;
          end
        end else begin
          act_q[0] <= act_gated[i*DATA_W +: DATA_W];
          wgt_q[0] <= wgt_gated[i*DATA_W +: DATA_W];
          for (int s = 1; s < i; s++) begin
            act_q[s] <= act_q[s-1];
            wgt_q[s] <= wgt_q[s-1];
          end
        end
      end

      assign act_out[i*DATA_W +: DATA_W] = act_q[i-1];
      assign wgt_out[i*DATA_W +: DATA_W] = wgt_q[i-1];
    end
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: SRAM models, per-cycle expected timeline and a PE-array sum model.
// Latency: checks outputs every cycle of a pass against the expected pass schedule.
// Backpressure: exercises delayed result_ack, ignored starts and mid-pass reset.
module tb_systolic_feed_ctrl;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int H  = 2*N + K + 1;  // first cycle of result_valid after start at edge 0

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [N*DW-1:0] act_rd_data;
  logic [N*DW-1:0] wgt_rd_data;
  logic [N*DW-1:0] act_out;
  logic [N*DW-1:0] wgt_out;
  logic            pe_en;
  logic            pe_clr;
  logic            result_valid;
  logic            result_ack;

  int n_checks = 0;
  int n_errors = 0;

  logic [N*DW-1:0] act_mem [K];
  logic [N*DW-1:0] wgt_mem [K];

  typedef struct packed {
    logic            busy;
    logic            rd_en;
    logic [AW-1:0]   addr;
    logic            pe_en;
    logic            pe_clr;
    logic            rv;
    logic [N*DW-1:0] act;
    logic [N*DW-1:0] wgt;
  } exp_t;

  systolic_feed_ctrl #(.N(N), .K(K), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .act_rd_data  (act_rd_data),
    .wgt_rd_data  (wgt_rd_data),
    .act_out      (act_out),
    .wgt_out      (wgt_out),
    .pe_en        (pe_en),
    .pe_clr       (pe_clr),
    .result_valid (result_valid),
    .result_ack   (result_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAMs with one-cycle read latency; data holds when not strobed.
  always @(posedge clk) begin
    if (rd_en) begin
      act_rd_data <= act_mem[rd_addr];
      wgt_rd_data <= wgt_mem[rd_addr];
    end
  end

  // Expected outputs in cycle c of a pass whose start is sampled at edge 0 and ack at edge a.
  function automatic exp_t expect_at(input int c, input int a);
    exp_t e;
    int   k;
    e = '0;
    e.busy   = (c >= 1) && (c <= a);
    e.rd_en  = (c >= 1) && (c <= K);
    e.addr   = ((c >= 1) && (c <= K)) ? AW'(c - 1) : '0;
    e.pe_clr = (c == 1);
    e.pe_en  = (c >= 2) && (c <= 2*N + K);
    e.rv     = (c >= H) && (c <= a);
    for (int i = 0; i < N; i++) begin
      k = c - 2 - i;
      if (k >= 0 && k < K) begin
        e.act[i*DW +: DW] = act_mem[k][i*DW +: DW];
        e.wgt[i*DW +: DW] = wgt_mem[k][i*DW +: DW];
      end
    end
    return e;
  endfunction

  // One full pass: hold = HOLD cycles before ack, optional stray starts/acks mid-pass.
  task automatic run_pass(input string name, input int hold, input bit stray, input bit start_w_ack);
    exp_t            q[$];
    exp_t            e;
    exp_t            got;
    logic [N*DW-1:0] act_h [64];
    logic [N*DW-1:0] wgt_h [64];
    bit              en_h  [64];
    bit              clr_h [64];
    int              a;
    int              last;
    longint          acc;
    longint          want;
    longint          av;
    longint          wv;
    a    = H + hold;
    last = a + 4;
    q.push_back(expect_at(0, a));
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      e          = q.pop_front();
      got.busy   = busy;
      got.rd_en  = rd_en;
      got.addr   = rd_addr;
      got.pe_en  = pe_en;
      got.pe_clr = pe_clr;
      got.rv     = result_valid;
      got.act    = act_out;
      got.wgt    = wgt_out;
      act_h[c] = act_out;
      wgt_h[c] = wgt_out;
      en_h[c]  = pe_en;
      clr_h[c] = pe_clr;
      n_checks++;
      if ({got.busy, got.rd_en, got.addr, got.pe_en, got.pe_clr, got.rv} !==
          {e.busy, e.rd_en, e.addr, e.pe_en, e.pe_clr, e.rv}) begin
        n_errors++;
        $display("FAIL %s ctrl cycle %0d: busy/rd_en/addr/pe_en/pe_clr/rv got %b %b %0d %b %b %b exp %b %b %0d %b %b %b",
                 name, c, got.busy, got.rd_en, got.addr, got.pe_en, got.pe_clr, got.rv,
                 e.busy, e.rd_en, e.addr, e.pe_en, e.pe_clr, e.rv);
      end
      n_checks++;
      if (got.act !== e.act) begin
        n_errors++;
        $display("FAIL %s act_out cycle %0d: got %h exp %h", name, c, got.act, e.act);
      end
      n_checks++;
      if (got.wgt !== e.wgt) begin
        n_errors++;
        $display("FAIL %s wgt_out cycle %0d: got %h exp %h", name, c, got.wgt, e.wgt);
      end
      start      = (c == 0) || (stray && (c == 3 || c == 9)) || (start_w_ack && c == a);
      result_ack = (c == a) || (stray && c == 4);
      q.push_back(expect_at(c + 1, a));
    end
    start      = 1'b0;
    result_ack = 1'b0;
    // PE(i,j) sees act lane i delayed j more cycles and wgt lane j delayed i more cycles.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc  = 0;
        want = 0;
        for (int k = 0; k < K; k++) begin
          want += longint'(act_mem[k][i*DW +: DW]) * longint'(wgt_mem[k][j*DW +: DW]);
        end
        for (int t = 0; t <= last; t++) begin
          if (clr_h[t]) begin
            acc = 0;
          end else if (en_h[t]) begin
            av = (t - j >= 0) ? longint'(act_h[t-j][i*DW +: DW]) : 0;
            wv = (t - i >= 0) ? longint'(wgt_h[t-i][j*DW +: DW]) : 0;
            acc += av * wv;
          end
        end
        n_checks++;
        if (acc !== want) begin
          n_errors++;
          $display("FAIL %s pe_sum(%0d,%0d): got %0d exp %0d", name, i, j, acc, want);
        end
      end
    end
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if ({busy, rd_en, rd_addr, pe_en, pe_clr, result_valid, act_out, wgt_out} !== '0) begin
      n_errors++;
      $display("FAIL %s outputs: busy %b rd_en %b addr %0d pe_en %b pe_clr %b rv %b act %h wgt %h exp all 0",
               name, busy, rd_en, rd_addr, pe_en, pe_clr, result_valid, act_out, wgt_out);
    end
  endtask

  task automatic load_pattern(input bit random_data);
    for (int k = 0; k < K; k++) begin
      for (int i = 0; i < N; i++) begin
        act_mem[k][i*DW +: DW] = random_data ? DW'($urandom) : DW'(i + 1);
        wgt_mem[k][i*DW +: DW] = random_data ? DW'($urandom) : DW'(1);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1 check_zero("reset_async");
    @(negedge clk);
    check_zero("reset_held");
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_zero("reset_release");
    end
  endtask

  task automatic test_basic_pass();
    load_pattern(1'b0);
    run_pass("basic_pass", 0, 1'b0, 1'b0);
  endtask

  task automatic test_word_order();
    load_pattern(1'b1);
    run_pass("word_order", 1, 1'b0, 1'b0);
  endtask

  task automatic test_stray_start();
    load_pattern(1'b1);
    run_pass("stray_start", 0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    load_pattern(1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    n_checks++;
    if (busy !== 1'b1 || pe_en !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid pre-reset busy/pe_en: got %b %b exp 1 1", busy, pe_en);
    end
    rst = 1'b1;
    #1 check_zero("reset_mid_async");
    @(negedge clk);
    check_zero("reset_mid_held");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_mid_after");
    end
    run_pass("rerun_after_reset", 0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_ack();
    load_pattern(1'b1);
    run_pass("hold_ack", 5, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    load_pattern(1'b1);
    run_pass("back_to_back_a", 0, 1'b0, 1'b0);
    load_pattern(1'b1);
    run_pass("back_to_back_b", 2, 1'b0, 1'b0);
  endtask

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    result_ack  = 1'b0;
    act_rd_data = '0;
    wgt_rd_data = '0;
    test_reset();
    test_basic_pass();
    test_word_order();
    test_stray_start();
    test_reset_mid();
    test_hold_ack();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
